// File: rtl/cached_dual_port_memory_if.sv
// Bus bundle for the memory subsystem: loader port A plus the processor cache port.
interface cached_dual_port_memory_if;
  logic        a_en;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_din;
  logic [15:0] a_dout;
  logic        pro_en;
  logic        pro_req;
  logic        pro_we;
  logic [15:0] pro_addr;
  logic [15:0] pro_wdata;
  logic [15:0] pro_rdata;
  logic        pro_ready;
  logic        hit;

  modport master (
    output a_en, a_we, a_addr, a_din,
    output pro_en, pro_req, pro_we, pro_addr, pro_wdata,
    input  a_dout, pro_rdata, pro_ready, hit
  );

  modport slave (
    input  a_en, a_we, a_addr, a_din,
    input  pro_en, pro_req, pro_we, pro_addr, pro_wdata,
    output a_dout, pro_rdata, pro_ready, hit
  );
endinterface

// File: rtl/cached_dual_port_memory.sv
// Clock-enable divider, dual-port word RAM and a direct-mapped write-through
// cache in front of RAM port B. Everything except the divider moves on ce.
module cached_dual_port_memory #(
  parameter int DIV    = 5,
  parameter int MEM_AW = 10,
  parameter int IDX_W  = 4
) (
  input  logic                      clk_100,
  input  logic                      rst,
  output logic                      ce,
  output logic                      clk_div,
  cached_dual_port_memory_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 16 - IDX_W;
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic {IDLE, FILL} state_t;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             clk_div_d, clk_div_q;

  // Divider next state: wrap at DIV-1 and toggle the square wave there
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    clk_div_d = clk_div_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      clk_div_d = ~clk_div_q;
    end
  end

  assign ce      = (cnt_q == CNT_LAST) && !clk_div_q;
  assign clk_div = clk_div_q;

  // Divider registers
  always_ff @(posedge clk_100) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
    end
  end

  logic [15:0]       mem [DEPTH];
  logic              a_wr;
  logic [MEM_AW-1:0] a_word;
  logic              b_en, b_we;
  logic [MEM_AW-1:0] b_word;
  logic [15:0]       b_wdata, b_rdata_q, a_dout_q;

  assign a_wr   = bus.a_en && bus.a_we;
  assign a_word = bus.a_addr[MEM_AW-1:0];

  // RAM array; port B is applied last so it wins a same-word double write
  always_ff @(posedge clk_100) begin
    if (ce) begin
      if (a_wr) mem[a_word] <= bus.a_din;
      if (b_en && b_we) mem[b_word] <= b_wdata;
      if (b_en && !b_we) b_rdata_q <= mem[b_word];
    end
  end

  // Port A read register, write-first
  always_ff @(posedge clk_100) begin
    if (rst) a_dout_q <= '0;
    else if (ce && bus.a_en) a_dout_q <= bus.a_we ? bus.a_din : mem[a_word];
  end

  logic [LINES-1:0] valid_d, valid_q;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [15:0]      data_mem [LINES];
  logic [IDX_W-1:0] look_idx, snoop_idx, line_idx;
  logic [TAG_W-1:0] look_tag, line_tag;
  logic [15:0]      line_data;
  logic             line_we, look_hit, snoop_hit, fill_clash;
  state_t           state_d, state_q;
  logic [15:0]      fill_addr_d, fill_addr_q;
  logic             fill_ok_d, fill_ok_q;
  logic [15:0]      rdata_d, rdata_q;
  logic             ready_d, ready_q, hit_d, hit_q;

  assign look_idx   = bus.pro_addr[IDX_W-1:0];
  assign look_tag   = bus.pro_addr[15:IDX_W];
  assign snoop_idx  = bus.a_addr[IDX_W-1:0];
  assign look_hit   = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);
  assign snoop_hit  = a_wr && valid_q[snoop_idx] && (tag_mem[snoop_idx] == bus.a_addr[15:IDX_W]);
  assign fill_clash = a_wr && (bus.a_addr == fill_addr_q);

  // Cache FSM: lookup in IDLE, one-tick line fill in FILL, snoop invalidation always
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_ok_d   = fill_ok_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    hit_d       = 1'b0;
    valid_d     = valid_q;
    line_we     = 1'b0;
    line_idx    = look_idx;
    line_tag    = look_tag;
    line_data   = bus.pro_wdata;
    b_en        = 1'b0;
    b_we        = 1'b0;
    b_word      = bus.pro_addr[MEM_AW-1:0];
    b_wdata     = bus.pro_wdata;

    if (snoop_hit) valid_d[snoop_idx] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.pro_en && bus.pro_req) begin
          if (bus.pro_we) begin
            b_en    = 1'b1;
            b_we    = 1'b1;
            ready_d = 1'b1;
            hit_d   = look_hit;
            line_we = look_hit;
          end else if (look_hit) begin
            rdata_d = data_mem[look_idx];
            ready_d = 1'b1;
            hit_d   = 1'b1;
          end else begin
            b_en        = 1'b1;
            fill_addr_d = bus.pro_addr;
            // a loader write racing the miss makes the fetched word stale
            fill_ok_d   = !(a_wr && (bus.a_addr == bus.pro_addr));
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        state_d = IDLE;
        if (bus.pro_en) begin
          rdata_d   = b_rdata_q;
          ready_d   = 1'b1;
          line_we   = 1'b1;
          line_idx  = fill_addr_q[IDX_W-1:0];
          line_tag  = fill_addr_q[15:IDX_W];
          line_data = b_rdata_q;
          valid_d[fill_addr_q[IDX_W-1:0]] = fill_ok_q && !fill_clash;
        end
      end
    endcase

    if (rst) begin
      b_en    = 1'b0;
      line_we = 1'b0;
    end
  end

  // Cache control registers
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      fill_ok_q   <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      valid_q     <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_ok_q   <= fill_ok_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      valid_q     <= valid_d;
    end
  end

  // Cache line storage, written on fills and write hits
  always_ff @(posedge clk_100) begin
    if (ce && line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  assign bus.a_dout    = a_dout_q;
  assign bus.pro_rdata = rdata_q;
  assign bus.pro_ready = ready_q;
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_cached_dual_port_memory.sv
// Bench for cached_dual_port_memory: transaction-level model of RAM and cache,
// per-tick output comparison, per-cycle divider comparison, directed scenarios
// with literal expectations, then randomized traffic.
module tb_cached_dual_port_memory;
  localparam int DIV = 5;
  localparam int PER = 2 * DIV;
  localparam int DEPTH = 1024;
  localparam int LINES = 16;

  logic clk_100 = 1'b0;
  logic rst = 1'b1;
  logic ce, clk_div;

  cached_dual_port_memory_if bus();

  cached_dual_port_memory #(.DIV(DIV), .MEM_AW(10), .IDX_W(4)) dut (
    .clk_100(clk_100), .rst(rst), .ce(ce), .clk_div(clk_div), .bus(bus)
  );

  always #5 clk_100 = ~clk_100;

  int checks = 0;
  int failures = 0;
  int k = 0;

  // reference model state
  logic [15:0] m_ram [DEPTH];
  bit          m_valid [LINES];
  logic [11:0] m_tag [LINES];
  logic [15:0] m_data [LINES];
  bit          m_fill, m_fill_ok;
  logic [15:0] m_fill_addr, m_fill_data;
  logic [15:0] e_rdata, e_adout;
  bit          e_ready, e_hit;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk_100);
    if (rst) k = 0; else k++;
    #1;
    check16("ce", ce, ((k % PER) == DIV - 1));
    check16("clk_div", clk_div, ((k / DIV) % 2) == 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    m_fill = 0; e_ready = 0; e_hit = 0; e_rdata = '0; e_adout = '0;
  endtask

  // One ce tick of the specified behaviour, from the inputs currently driven
  task automatic model_step();
    bit a_wr, snoop, lhit, bwr, install;
    logic [3:0] ia, ip;
    a_wr = bus.a_en && bus.a_we;
    bwr = 0; install = 0; ip = '0;
    e_ready = 0; e_hit = 0;
    if (bus.a_en) e_adout = bus.a_we ? bus.a_din : m_ram[bus.a_addr[9:0]];
    ia = bus.a_addr[3:0];
    snoop = a_wr && m_valid[ia] && (m_tag[ia] == bus.a_addr[15:4]);
    if (m_fill) begin
      m_fill = 0;
      if (bus.pro_en) begin
        e_rdata = m_fill_data; e_ready = 1; install = 1; ip = m_fill_addr[3:0];
      end
    end else if (bus.pro_en && bus.pro_req) begin
      ip = bus.pro_addr[3:0];
      lhit = m_valid[ip] && (m_tag[ip] == bus.pro_addr[15:4]);
      if (bus.pro_we) begin
        bwr = 1; e_ready = 1; e_hit = lhit;
        if (lhit) m_data[ip] = bus.pro_wdata;
      end else if (lhit) begin
        e_rdata = m_data[ip]; e_ready = 1; e_hit = 1;
      end else begin
        m_fill = 1; m_fill_addr = bus.pro_addr;
        m_fill_data = m_ram[bus.pro_addr[9:0]];
        m_fill_ok = !(a_wr && bus.a_addr == bus.pro_addr);
      end
    end
    if (snoop) m_valid[ia] = 0;
    if (install) begin
      m_valid[ip] = m_fill_ok && !(a_wr && bus.a_addr == m_fill_addr);
      m_tag[ip] = m_fill_addr[15:4];
      m_data[ip] = m_fill_data;
    end
    if (a_wr) m_ram[bus.a_addr[9:0]] = bus.a_din;
    if (bwr) m_ram[bus.pro_addr[9:0]] = bus.pro_wdata;
  endtask

  task automatic tick();
    for (int i = 0; i < PER && (k % PER) != DIV - 1; i++) clk_cycle();
    model_step();
    clk_cycle();
    check16("pro_ready", bus.pro_ready, e_ready);
    check16("hit", bus.hit, e_hit);
    check16("pro_rdata", bus.pro_rdata, e_rdata);
    check16("a_dout", bus.a_dout, e_adout);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    bus.pro_req = 0; bus.a_en = 0; bus.a_we = 0;
    repeat (n) clk_cycle();
    model_reset();
    check16("rst_ready", bus.pro_ready, 16'h0);
    check16("rst_hit", bus.hit, 16'h0);
    check16("rst_rdata", bus.pro_rdata, 16'h0);
    check16("rst_adout", bus.a_dout, 16'h0);
    rst = 0;
  endtask

  task automatic porta(input bit we, input logic [15:0] addr, input logic [15:0] din);
    bus.a_en = 1; bus.a_we = we; bus.a_addr = addr; bus.a_din = din;
    tick();
    bus.a_en = 0; bus.a_we = 0;
  endtask

  task automatic proc_access(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                             output int lat);
    bus.pro_en = 1; bus.pro_req = 1; bus.pro_we = we; bus.pro_addr = addr; bus.pro_wdata = wd;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.pro_ready) begin lat = i; break; end
    end
    bus.pro_req = 0;
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL proc_access_timeout addr=%h actual=no_ready required=ready", addr);
    end
  endtask

  function automatic logic [15:0] pool_addr();
    logic [15:0] t;
    t = 16'(($urandom % 4) * 16 + ($urandom % 8));
    return t;
  endfunction

  initial begin
    int lat, hi;
    int ce_at[$];
    for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
    bus.a_en = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_din = '0;
    bus.pro_en = 0; bus.pro_req = 0; bus.pro_we = 0; bus.pro_addr = '0; bus.pro_wdata = '0;
    model_reset();
    do_reset(3);

    // divider after release: ticks at 4, 14, 24; clk_div high 5 of every 10
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      clk_cycle();
      if (ce) ce_at.push_back(k);
      if (clk_div) hi++;
    end
    check16("ce_count", 16'(ce_at.size()), 16'd3);
    if (ce_at.size() == 3) begin
      check16("ce_first", 16'(ce_at[0]), 16'd4);
      check16("ce_second", 16'(ce_at[1]), 16'd14);
      check16("ce_third", 16'(ce_at[2]), 16'd24);
    end
    check16("clk_div_high", 16'(hi), 16'd15);

    // preload the address pool used by every scenario
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 8; i++) porta(1, 16'(t * 16 + i), 16'($urandom));

    // port A write-first, read, aliasing
    porta(1, 16'h0010, 16'h1234);
    check16("a_wfirst", bus.a_dout, 16'h1234);
    porta(0, 16'h0010, 16'h0);
    check16("a_read", bus.a_dout, 16'h1234);
    porta(1, 16'h0410, 16'h4321);
    porta(0, 16'h0010, 16'h0);
    check16("a_alias", bus.a_dout, 16'h4321);

    // cold read then hit
    porta(1, 16'h0003, 16'hBEEF);
    proc_access(0, 16'h0003, 16'h0, lat);
    check16("cold_lat", 16'(lat), 16'd2);
    check16("cold_hit", bus.hit, 16'h0);
    check16("cold_data", bus.pro_rdata, 16'hBEEF);
    proc_access(0, 16'h0003, 16'h0, lat);
    check16("warm_lat", 16'(lat), 16'd1);
    check16("warm_hit", bus.hit, 16'h1);
    check16("warm_data", bus.pro_rdata, 16'hBEEF);

    // conflict on index 3
    porta(1, 16'h0013, 16'h1313);
    proc_access(0, 16'h0013, 16'h0, lat);
    check16("conf_lat", 16'(lat), 16'd2);
    check16("conf_data", bus.pro_rdata, 16'h1313);
    proc_access(0, 16'h0003, 16'h0, lat);
    check16("conf_back_lat", 16'(lat), 16'd2);
    check16("conf_back_hit", bus.hit, 16'h0);

    // write-through on a hit, no allocate on a miss
    proc_access(1, 16'h0003, 16'hAAAA, lat);
    check16("wt_lat", 16'(lat), 16'd1);
    check16("wt_hit", bus.hit, 16'h1);
    porta(0, 16'h0003, 16'h0);
    check16("wt_ram", bus.a_dout, 16'hAAAA);
    proc_access(0, 16'h0003, 16'h0, lat);
    check16("wt_line", bus.pro_rdata, 16'hAAAA);
    check16("wt_line_hit", bus.hit, 16'h1);
    proc_access(1, 16'h0023, 16'h2323, lat);
    check16("wmiss_hit", bus.hit, 16'h0);
    proc_access(0, 16'h0023, 16'h0, lat);
    check16("noalloc_lat", 16'(lat), 16'd2);
    check16("noalloc_data", bus.pro_rdata, 16'h2323);

    // snoop invalidation
    proc_access(0, 16'h0005, 16'h0, lat);
    proc_access(0, 16'h0005, 16'h0, lat);
    check16("snoop_pre_hit", bus.hit, 16'h1);
    porta(1, 16'h0005, 16'h5555);
    proc_access(0, 16'h0005, 16'h0, lat);
    check16("snoop_lat", 16'(lat), 16'd2);
    check16("snoop_data", bus.pro_rdata, 16'h5555);

    // loader write during the fill tick: old data returned, line not kept
    porta(1, 16'h0006, 16'h0606);
    bus.pro_en = 1; bus.pro_req = 1; bus.pro_we = 0; bus.pro_addr = 16'h0006;
    tick();
    bus.pro_req = 0;
    bus.a_en = 1; bus.a_we = 1; bus.a_addr = 16'h0006; bus.a_din = 16'h6666;
    tick();
    bus.a_en = 0; bus.a_we = 0;
    check16("race_ready", bus.pro_ready, 16'h1);
    check16("race_data", bus.pro_rdata, 16'h0606);
    proc_access(0, 16'h0006, 16'h0, lat);
    check16("race_refetch_lat", 16'(lat), 16'd2);
    check16("race_refetch", bus.pro_rdata, 16'h6666);

    // pro_en dropped during fill
    bus.pro_en = 1; bus.pro_req = 1; bus.pro_we = 0; bus.pro_addr = 16'h0007;
    tick();
    bus.pro_req = 0; bus.pro_en = 0;
    tick();
    check16("abort_ready", bus.pro_ready, 16'h0);
    proc_access(0, 16'h0007, 16'h0, lat);
    check16("abort_lat", 16'(lat), 16'd2);

    // reset in the middle of a fill
    bus.pro_en = 1; bus.pro_req = 1; bus.pro_we = 0; bus.pro_addr = 16'h0015;
    tick();
    do_reset(2);
    proc_access(0, 16'h0015, 16'h0, lat);
    check16("rstfill_lat", 16'(lat), 16'd2);
    proc_access(0, 16'h0003, 16'h0, lat);
    check16("rst_clears_lat", 16'(lat), 16'd2);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      bus.pro_en = ($urandom % 8) != 0;
      bus.pro_req = $urandom % 2;
      bus.pro_we = ($urandom % 4) == 0;
      bus.pro_addr = pool_addr();
      bus.pro_wdata = 16'($urandom);
      bus.a_en = ($urandom % 4) == 0;
      bus.a_we = $urandom % 2;
      bus.a_addr = pool_addr();
      bus.a_din = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
